// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    POWER_WAIT,
    INIT_LOAD,
    SETUP,
    E_HIGH,
    HOLD,
    WAIT,
    IDLE
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT     = 8'h03;
  localparam logic [7:0] CMD_ENTRY        = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;

  localparam int INIT_LEN = 7;

  // Entry 0 is the rightmost element: 38 38 38 38 0C 01 06.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    CMD_ENTRY, CMD_CLEAR, CMD_DISPLAY_ON,
    CMD_FUNC_8BIT_2L, CMD_FUNC_8BIT_2L, CMD_FUNC_8BIT_2L, CMD_FUNC_8BIT_2L
  };

  // Clear and return-home need the long execution delay; 0x03 decodes as home too.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && (b == CMD_CLEAR || b == CMD_HOME || b == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-up initialisation byte table, indexed by init step.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] idx_i,
  output logic [7:0] byte_o
);

  // Out-of-range index reads as 0x00; the sequencer never goes past INIT_LEN-1.
  always_comb begin
    byte_o = 8'h00;
    if (int'(idx_i) < INIT_LEN) byte_o = INIT_ROM[idx_i];
  end

endmodule

// File: rtl/lcd_sequencer.sv
// Character-LCD write sequencer: runs the init sequence after reset/reinit,
// then serialises single-byte writes with enforced E width, hold and
// execution delay.
//
// Every init byte costs one INIT_LOAD cycle on top of SETUP, so init takes
//   T_POWER + 7*(2+T_E_HIGH+T_HOLD) + 6*T_EXEC + T_CLEAR
// clock edges after reset release; init enable pulses are spaced
// 2+T_E_HIGH+T_HOLD+Twait cycles. Host writes cost 2+T_E_HIGH+T_HOLD+Twait
// cycles from one acceptance edge to the next. T_POWER must be >= 2.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWER  = 750000,
  parameter int unsigned T_E_HIGH = 12,
  parameter int unsigned T_HOLD   = 4,
  parameter int unsigned T_EXEC   = 2500,
  parameter int unsigned T_CLEAR  = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       reinit,
  output logic       init_done,
  output logic       rw,
  output logic       rs,
  output logic       enable,
  output logic [7:0] display
);

  localparam int unsigned M1    = (T_POWER > T_E_HIGH) ? T_POWER : T_E_HIGH;
  localparam int unsigned M2    = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
  localparam int unsigned M3    = (M1 > M2) ? M1 : M2;
  localparam int unsigned T_MAX = (M3 > T_CLEAR) ? M3 : T_CLEAR;
  localparam int          TW    = $clog2(T_MAX) + 1;

  lcd_state_e    state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    idx_q;
  logic          pw_armed_q;  // POWER_WAIT has loaded its count
  logic          rs_q, enable_q, wr_ready_q, init_done_q;
  logic [7:0]    display_q;
  logic [7:0]    rom_byte;

  lcd_init_rom u_rom (
    .idx_i  (idx_q),
    .byte_o (rom_byte)
  );

  // Sequencer FSM; the timer reloads with (length-1) on entry and the state
  // exits on the cycle it reads zero. POWER_WAIT loads in its own first cycle
  // because reset leaves the timer at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= POWER_WAIT;
      timer_q     <= '0;
      idx_q       <= '0;
      pw_armed_q  <= 1'b0;
      rs_q        <= 1'b0;
      enable_q    <= 1'b0;
      display_q   <= 8'h00;
      wr_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        POWER_WAIT: begin
          if (!pw_armed_q) begin
            pw_armed_q <= 1'b1;
            timer_q    <= TW'(T_POWER - 2);
          end else if (timer_q == '0) begin
            state_q <= INIT_LOAD;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        INIT_LOAD: begin
          rs_q      <= 1'b0;
          display_q <= rom_byte;
          state_q   <= SETUP;
        end
        SETUP: begin
          enable_q <= 1'b1;
          timer_q  <= TW'(T_E_HIGH - 1);
          state_q  <= E_HIGH;
        end
        E_HIGH: begin
          if (timer_q == '0) begin
            enable_q <= 1'b0;
            timer_q  <= TW'(T_HOLD - 1);
            state_q  <= HOLD;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        HOLD: begin
          if (timer_q == '0) begin
            timer_q <= is_long_cmd(rs_q, display_q) ? TW'(T_CLEAR - 1) : TW'(T_EXEC - 1);
            state_q <= WAIT;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        WAIT: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else if (!init_done_q && int'(idx_q) != INIT_LEN - 1) begin
            idx_q   <= idx_q + 3'd1;
            state_q <= INIT_LOAD;
          end else begin
            init_done_q <= 1'b1;
            wr_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        IDLE: begin
          // reinit has priority; a coincident write is dropped.
          if (reinit) begin
            init_done_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            idx_q       <= '0;
            pw_armed_q  <= 1'b0;
            state_q     <= POWER_WAIT;
          end else if (wr_valid) begin
            rs_q       <= wr_rs;
            display_q  <= wr_data;
            wr_ready_q <= 1'b0;
            state_q    <= SETUP;
          end
        end
        default: state_q <= POWER_WAIT;
      endcase
    end
  end

  assign rw        = 1'b0;
  assign rs        = rs_q;
  assign enable    = enable_q;
  assign display   = display_q;
  assign wr_ready  = wr_ready_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Randomised self-checking bench for lcd_sequencer. Cycle numbers name the
// clock edge that ends the cycle; outputs are sampled on the falling edge.
module tb_lcd_sequencer;

  localparam int T_POWER  = 20;
  localparam int T_E_HIGH = 3;
  localparam int T_HOLD   = 2;
  localparam int T_EXEC   = 5;
  localparam int T_CLEAR  = 10;
  localparam int N_INIT   = 7;
  // Init length including the one-cycle INIT_LOAD step per byte.
  localparam int INIT_CYC = T_POWER + N_INIT*(2+T_E_HIGH+T_HOLD) + 6*T_EXEC + T_CLEAR;

  typedef struct {
    int         start;
    int         width;
    logic       rs;
    logic [7:0] data;
  } pulse_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid = 1'b0, wr_rs = 1'b0, reinit = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, init_done, rw, rs, enable;
  logic [7:0] display;

  int n_chk = 0, n_fail = 0, cyc = 0;
  pulse_t pulses[$];
  pulse_t exp_q[$];
  logic [7:0] rom_ref [N_INIT] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_sequencer #(
    .T_POWER(T_POWER), .T_E_HIGH(T_E_HIGH), .T_HOLD(T_HOLD),
    .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
  ) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_rs(wr_rs),
    .wr_data(wr_data), .wr_ready(wr_ready), .reinit(reinit),
    .init_done(init_done), .rw(rw), .rs(rs), .enable(enable), .display(display)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int twait(input logic r, input logic [7:0] d);
    return (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? T_CLEAR : T_EXEC;
  endfunction

  // Pulse recorder: logs every enable pulse and checks the bus is steady under it.
  always @(negedge clk) begin : mon
    static logic   en_prev = 1'b0;
    static pulse_t cur;
    if (enable && !en_prev) begin
      cur.start = cyc + 1; cur.width = 1; cur.rs = rs; cur.data = display;
    end else if (enable) begin
      cur.width = cur.width + 1;
      chk("bus_stable_under_e", {23'd0, rs, display}, {23'd0, cur.rs, cur.data});
    end else if (en_prev) begin
      pulses.push_back(cur);
    end
    en_prev = enable;
  end

  // Waits for init completion from reference cycle rel and checks the byte stream.
  task automatic check_init(input int rel);
    int cnt = 0;
    int t;
    logic early = 1'b0;
    while (!init_done && cnt < 2*INIT_CYC) begin
      if (wr_ready) early = 1'b1;
      @(negedge clk); cnt++;
    end
    chk("init_cycles", cyc - rel, INIT_CYC);
    chk("ready_before_init", early, 1'b0);
    chk("ready_at_init", wr_ready, 1'b1);
    chk("init_pulse_count", pulses.size(), N_INIT);
    t = T_POWER + 3;
    for (int i = 0; i < N_INIT; i++) begin
      if (i < pulses.size()) begin
        chk("init_pulse_start", pulses[i].start - rel, t);
        chk("init_pulse_width", pulses[i].width, T_E_HIGH);
        chk("init_rs", pulses[i].rs, 1'b0);
        chk("init_byte", pulses[i].data, rom_ref[i]);
      end
      t += 2 + T_E_HIGH + T_HOLD + twait(1'b0, rom_ref[i]);
    end
    pulses.delete();
  endtask

  // One write through the handshake; valid stays high with junk after acceptance.
  task automatic write_one(input logic r, input logic [7:0] d, input int gap, input logic rin);
    int k, cnt;
    logic ok;
    wr_valid = 1'b0;
    repeat (gap) @(negedge clk);
    wr_valid = 1'b1; wr_rs = r; wr_data = d;
    cnt = 0;
    while (!wr_ready && cnt < 200) begin @(negedge clk); cnt++; end
    chk("accept_wait", wr_ready, 1'b1);
    k = cyc + 1;
    exp_q.push_back('{start: k + 2, width: T_E_HIGH, rs: r, data: d});
    @(negedge clk);
    wr_rs = 1'($urandom); wr_data = 8'($urandom);
    reinit = rin;
    chk("ready_drop", wr_ready, 1'b0);
    ok = 1'b1; cnt = 0;
    while (!wr_ready && cnt < 200) begin
      if (cyc <= k + T_E_HIGH + T_HOLD && (display !== d || rs !== r)) ok = 1'b0;
      @(negedge clk); cnt++;
      reinit = 1'b0;
    end
    chk("bus_hold", ok, 1'b1);
    chk("ready_return", cyc + 1 - k, 2 + T_E_HIGH + T_HOLD + twait(r, d));
    chk("init_kept", init_done, 1'b1);
  endtask

  task automatic compare_pulses();
    chk("pulse_count", pulses.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < pulses.size()) begin
        chk("pulse_start", pulses[i].start, exp_q[i].start);
        chk("pulse_width", pulses[i].width, exp_q[i].width);
        chk("pulse_rs", pulses[i].rs, exp_q[i].rs);
        chk("pulse_data", pulses[i].data, exp_q[i].data);
      end
    end
    pulses.delete();
    exp_q.delete();
  endtask

  task automatic random_writes(input int n);
    logic r;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = 1'b0; d = 8'($urandom_range(1, 3));
      end else begin
        r = 1'($urandom); d = 8'($urandom);
      end
      write_one(r, d, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    int rel, cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_enable", enable, 1'b0);
    chk("rst_ready", wr_ready, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_rs", rs, 1'b0);
    chk("rst_display", display, 8'h00);
    chk("rw_low", rw, 1'b0);
    reset = 1'b0; rel = cyc;
    check_init(rel);

    // Directed writes: data, clear, plain command, home variants.
    write_one(1'b1, 8'h41, 0, 1'b0);
    write_one(1'b0, 8'h01, 0, 1'b0);
    write_one(1'b0, 8'h80, 0, 1'b0);
    write_one(1'b0, 8'h02, 1, 1'b0);
    write_one(1'b0, 8'h03, 0, 1'b0);
    write_one(1'b1, 8'h01, 0, 1'b0);
    wr_valid = 1'b0;
    compare_pulses();

    random_writes(14);
    compare_pulses();

    // Reset in the middle of an enable pulse.
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'hAA;
    cnt = 0;
    while (!wr_ready && cnt < 200) begin @(negedge clk); cnt++; end
    @(negedge clk);
    wr_valid = 1'b0;
    cnt = 0;
    while (!enable && cnt < 20) begin @(negedge clk); cnt++; end
    chk("e_high_reached", enable, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_enable", enable, 1'b0);
    chk("abort_ready", wr_ready, 1'b0);
    chk("abort_init_done", init_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    pulses.delete();
    @(negedge clk);
    reset = 1'b0; rel = cyc;
    check_init(rel);

    random_writes(4);
    compare_pulses();

    // reinit together with a write in IDLE: write dropped, init replays.
    reinit = 1'b1; wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    reinit = 1'b0; wr_valid = 1'b0;
    rel = cyc;
    chk("reinit_init_done", init_done, 1'b0);
    chk("reinit_ready", wr_ready, 1'b0);
    check_init(rel);

    random_writes(3);
    compare_pulses();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
